// File: rtl/tft_disp_sched.sv
// -----------------------------------------------------------------------------
// tft_disp_sched
//
// Power/display sequencer and pattern scheduler for the TFT colour-bar
// datapath. It brings the timing generator up after a power-settle delay and
// turns the backlight on only after a few frames of valid video. On shutdown
// it turns the backlight off first, lets video run a few more frames, then
// stops timing. It also picks the test pattern the pixel generator draws.
// A pattern change is only ever committed on a frame boundary.
//
// Optional feature macro: TFT_BL_PWM_EN
//   defined   : in ON, tft_bl = (pwm_cnt < bl_duty), pwm_cnt free-running 8 bit
//   undefined : tft_bl = 1 in ON, else 0; bl_duty is ignored
//
// Ports
//   sys_clk    in   system clock, vsync is synchronous to it
//   sys_rst_n  in   asynchronous active-low reset
//   disp_on    in   level: 1 = display wanted on, 0 = shut down
//   key_next   in   one-cycle debounced pulse: advance pattern
//   auto_en    in   level: advance pattern every AUTO_FRAMES frames
//   vsync      in   vertical sync from the timing generator
//   bl_duty    in   backlight duty 0..255 (PWM build only)
//   tim_en     out  enable to the timing generator
//   tft_bl     out  backlight control
//   pat_sel    out  pattern index to the pixel generator
//   pat_upd    out  one-cycle pulse on the cycle pat_sel changes
//   busy       out  1 in any state other than OFF and ON
// -----------------------------------------------------------------------------
module tft_disp_sched #(
  parameter int   T_PWR         = 1_000_000,
  parameter int   BL_ON_FRAMES  = 4,
  parameter int   BL_OFF_FRAMES = 2,
  parameter int   AUTO_FRAMES   = 120,
  parameter int   PAT_NUM       = 8,
  parameter logic VSYNC_POL     = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       disp_on,
  input  logic       key_next,
  input  logic       auto_en,
  input  logic       vsync,
  input  logic [7:0] bl_duty,
  output logic       tim_en,
  output logic       tft_bl,
  output logic [2:0] pat_sel,
  output logic       pat_upd,
  output logic       busy
);

  // Counter widths: each counter only has to reach (limit - 1).
  localparam int FRM_MAX = (BL_ON_FRAMES > BL_OFF_FRAMES) ? BL_ON_FRAMES : BL_OFF_FRAMES;
  localparam int PWR_W   = (T_PWR > 1)       ? $clog2(T_PWR)       : 1;
  localparam int FRM_W   = (FRM_MAX > 1)     ? $clog2(FRM_MAX)     : 1;
  localparam int AUTO_W  = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  localparam logic [PWR_W-1:0]  PWR_LAST    = PWR_W'(T_PWR - 1);
  localparam logic [FRM_W-1:0]  BL_ON_LAST  = FRM_W'(BL_ON_FRAMES - 1);
  localparam logic [FRM_W-1:0]  BL_OFF_LAST = FRM_W'(BL_OFF_FRAMES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST   = AUTO_W'(AUTO_FRAMES - 1);
  localparam logic [2:0]        PAT_LAST    = 3'(PAT_NUM - 1);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_VID_WAIT = 3'd2,
    ST_ON       = 3'd3,
    ST_BL_OFF   = 3'd4
  } state_t;

  state_t              state_q,      state_d;
  logic [PWR_W-1:0]    pwr_cnt_q,    pwr_cnt_d;
  logic [FRM_W-1:0]    frm_cnt_q,    frm_cnt_d;
  logic [AUTO_W-1:0]   auto_cnt_q,   auto_cnt_d;
  logic                pending_q,    pending_d;
  logic [2:0]          pat_sel_q,    pat_sel_d;
  logic                pat_upd_q,    pat_upd_d;
  logic                vsync_q,      vsync_d;
  logic                frame_tick_q, frame_tick_d;

  logic                tick;
  logic                pat_active;
  logic                auto_expire;
  logic                bl_on_state;

  // ---------------------------------------------------------------------------
  // Frame boundary detect: one-cycle pulse the cycle after vsync is first seen
  // at its active level. Ticks are ignored while timing is disabled.
  // ---------------------------------------------------------------------------
  always_comb begin
    vsync_d      = vsync;
    frame_tick_d = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
  end

  assign tick = frame_tick_q & tim_en;

  // ---------------------------------------------------------------------------
  // Power sequencing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = '0;
    frm_cnt_d = frm_cnt_q;

    case (state_q)
      ST_OFF: begin
        frm_cnt_d = '0;
        if (disp_on) begin
          state_d = ST_PWR_WAIT;
        end
      end

      ST_PWR_WAIT: begin
        if (!disp_on) begin
          state_d = ST_OFF;
        end else if (pwr_cnt_q == PWR_LAST) begin
          state_d = ST_VID_WAIT;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 1'b1;
        end
      end

      ST_VID_WAIT: begin
        // Backlight is still off here, so a shutdown goes straight to the
        // video-drain phase.
        if (!disp_on) begin
          state_d   = ST_BL_OFF;
          frm_cnt_d = '0;
        end else if (tick) begin
          if (frm_cnt_q == BL_ON_LAST) begin
            state_d   = ST_ON;
            frm_cnt_d = '0;
          end else begin
            frm_cnt_d = frm_cnt_q + 1'b1;
          end
        end
      end

      ST_ON: begin
        frm_cnt_d = '0;
        if (!disp_on) begin
          state_d = ST_BL_OFF;
        end
      end

      ST_BL_OFF: begin
        // Runs to completion even if disp_on comes back; the next power-up
        // always starts again from OFF.
        if (tick) begin
          if (frm_cnt_q == BL_OFF_LAST) begin
            state_d   = ST_OFF;
            frm_cnt_d = '0;
          end else begin
            frm_cnt_d = frm_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_OFF;
        frm_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pattern scheduler. Requests (key or auto expiry) only set a pending flag;
  // the flag is consumed on a frame tick, so pat_sel never moves mid-frame and
  // several requests within one frame collapse into a single advance.
  // ---------------------------------------------------------------------------
  assign pat_active = (state_q == ST_VID_WAIT) || (state_q == ST_ON);

  always_comb begin
    pending_d   = pending_q;
    auto_cnt_d  = auto_cnt_q;
    pat_sel_d   = pat_sel_q;
    pat_upd_d   = 1'b0;
    auto_expire = 1'b0;

    if (!pat_active) begin
      pending_d  = 1'b0;
      auto_cnt_d = '0;
    end else begin
      if (!auto_en) begin
        auto_cnt_d = '0;
      end else if (tick) begin
        if (auto_cnt_q == AUTO_LAST) begin
          auto_cnt_d  = '0;
          auto_expire = 1'b1;
        end else begin
          auto_cnt_d = auto_cnt_q + 1'b1;
        end
      end

      if (tick && pending_q) begin
        pat_sel_d = (pat_sel_q == PAT_LAST) ? 3'd0 : pat_sel_q + 3'd1;
        pat_upd_d = 1'b1;
        // An expiry landing on this tick merges with the advance being made
        // now; a key on this tick belongs to the next frame.
        pending_d = key_next;
      end else begin
        pending_d = pending_q | key_next | auto_expire;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_OFF;
      pwr_cnt_q    <= '0;
      frm_cnt_q    <= '0;
      auto_cnt_q   <= '0;
      pending_q    <= 1'b0;
      pat_sel_q    <= 3'd0;
      pat_upd_q    <= 1'b0;
      vsync_q      <= ~VSYNC_POL;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwr_cnt_q    <= pwr_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
      auto_cnt_q   <= auto_cnt_d;
      pending_q    <= pending_d;
      pat_sel_q    <= pat_sel_d;
      pat_upd_q    <= pat_upd_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Backlight drive
  // ---------------------------------------------------------------------------
  assign bl_on_state = (state_q == ST_ON);

`ifdef TFT_BL_PWM_EN
  logic [7:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Strict compare: duty 0 is always dark, duty 255 gives 255/256.
  assign tft_bl = bl_on_state && (pwm_cnt_q < bl_duty);
`else
  logic unused_bl_duty;
  assign unused_bl_duty = ^bl_duty;
  assign tft_bl         = bl_on_state;
`endif

  // ---------------------------------------------------------------------------
  // Outputs decoded straight from registers so reset clears them at once.
  // ---------------------------------------------------------------------------
  assign tim_en  = (state_q == ST_VID_WAIT) || (state_q == ST_ON) || (state_q == ST_BL_OFF);
  assign busy    = (state_q != ST_OFF) && (state_q != ST_ON);
  assign pat_sel = pat_sel_q;
  assign pat_upd = pat_upd_q;

endmodule
